// File: rtl/cq_sched_pkg.sv
// Shared constants and read-FSM encoding for the cq write/read scheduler.
package cq_sched_pkg;

    localparam int unsigned DataWidth = 8;
    localparam int unsigned StallWidth = 8;

    localparam logic [StallWidth-1:0] StallMax = 8'hFF;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    function automatic logic [StallWidth-1:0] sat_inc(input logic [StallWidth-1:0] v);
        return (v == StallMax) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cq_rr_arb2.sv
// Two-requester round-robin arbiter; the last winner loses the next tie.
module cq_rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic write,
    output logic grant
);

    logic last_gnt_q;
    logic last_gnt_d;

    always_comb begin
        grant = 1'b0;
        if (req0 && req1) begin
            grant = ~last_gnt_q;
        end else if (req1) begin
            grant = 1'b1;
        end
    end

    // Priority only moves when a word is actually written.
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (write) begin
            last_gnt_d = grant;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/cq_sched.sv
// Schedules two producers into an external cq and paces consumer reads from it.
module cq_sched
    import cq_sched_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [DataWidth-1:0]  din0,
    input  logic [DataWidth-1:0]  din1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  q_wr,
    output logic [DataWidth-1:0]  q_din,
    input  logic                  q_full,
    output logic                  q_rd,
    input  logic                  q_empty,
    input  logic [DataWidth-1:0]  q_dout,
    input  logic                  rd_req,
    output logic                  rd_valid,
    output logic [DataWidth-1:0]  rd_data,
    output logic [StallWidth-1:0] stall_cnt
);

    logic grant;
    logic any_req;

    assign any_req = req0 | req1;

    cq_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .req1  (req1),
        .write (q_wr),
        .grant (grant)
    );

    always_comb begin
        q_wr  = any_req & ~q_full & ~reset;
        ack0  = q_wr & ~grant;
        ack1  = q_wr & grant;
        q_din = '0;
        if (q_wr) begin
            q_din = grant ? din1 : din0;
        end
    end

    logic [StallWidth-1:0] stall_q;
    logic [StallWidth-1:0] stall_d;

    always_comb begin
        stall_d = stall_q;
        if (any_req && q_full) begin
            stall_d = sat_inc(stall_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;

    rd_state_e state_q;
    rd_state_e state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= R_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            R_IDLE: if (rd_req && !q_empty) state_d = R_DATA;
            R_DATA: state_d = R_IDLE;
            default: state_d = R_IDLE;
        endcase
    end

    // A word popped just before reset is dropped: outputs are masked while reset is high.
    always_comb begin
        q_rd     = 1'b0;
        rd_valid = 1'b0;
        rd_data  = '0;
        if (!reset) begin
            unique case (state_q)
                R_IDLE: q_rd = rd_req & ~q_empty;
                R_DATA: begin
                    rd_valid = 1'b1;
                    rd_data  = q_dout;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cq_sched.sv
// Randomised bench for cq_sched with a behavioural model and a few directed literal checks.
module tb_cq_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [7:0] din0, din1;
    logic       ack0, ack1;
    logic       q_wr;
    logic [7:0] q_din;
    logic       q_full;
    logic       q_rd;
    logic       q_empty;
    logic [7:0] q_dout;
    logic       rd_req;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [7:0] stall_cnt;

    cq_sched dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .din0      (din0),
        .din1      (din1),
        .ack0      (ack0),
        .ack1      (ack1),
        .q_wr      (q_wr),
        .q_din     (q_din),
        .q_full    (q_full),
        .q_rd      (q_rd),
        .q_empty   (q_empty),
        .q_dout    (q_dout),
        .rd_req    (rd_req),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: who wins the next tie, stall count, whether a word was popped last cycle.
    int  m_tie;
    int  m_stall;
    bit  m_pending;
    bit  m_live = 0;

    bit       e_wr, e_ack0, e_ack1, e_rd, e_valid;
    int       e_gnt;
    logic [7:0] e_din, e_rdata;

    task automatic model_eval();
        bit any;
        any = req0 || req1;
        if (req0 && req1) e_gnt = m_tie;
        else if (req1)    e_gnt = 1;
        else              e_gnt = 0;
        e_wr    = any && !q_full && !reset;
        e_ack0  = e_wr && e_gnt == 0;
        e_ack1  = e_wr && e_gnt == 1;
        e_din   = !e_wr ? 8'h00 : (e_gnt == 1 ? din1 : din0);
        e_valid = m_pending && !reset;
        e_rd    = !reset && !m_pending && rd_req && !q_empty;
        e_rdata = e_valid ? q_dout : 8'h00;
    endtask

    always @(posedge clk) begin
        model_eval();
        if (reset) begin
            m_tie     = 0;
            m_stall   = 0;
            m_pending = 0;
            m_live    = 1;
        end else if (m_live) begin
            if (e_wr) m_tie = 1 - e_gnt;
            if ((req0 || req1) && q_full && m_stall < 255) m_stall++;
            m_pending = e_rd;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            model_eval();
            chk("q_wr", q_wr, e_wr);
            chk("ack0", ack0, e_ack0);
            chk("ack1", ack1, e_ack1);
            chk("q_din", q_din, e_din);
            chk("q_rd", q_rd, e_rd);
            chk("rd_valid", rd_valid, e_valid);
            chk("rd_data", rd_data, e_rdata);
            chk("stall_cnt", stall_cnt, m_stall);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0 = 0; req1 = 0; din0 = 0; din1 = 0;
        q_full = 0; q_empty = 1; q_dout = 0; rd_req = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        step();
        reset = 0;
    endtask

    logic [7:0] exp_seq [4];

    initial begin
        reset = 1;
        idle_inputs();
        step();
        chk("rst_stall", stall_cnt, 8'h00);
        chk("rst_q_wr", q_wr, 1'b0);
        step();
        reset = 0;

        // Single requester is granted in the same cycle.
        req0 = 1; din0 = 8'h0A;
        #2;
        chk("single_q_wr", q_wr, 1'b1);
        chk("single_q_din", q_din, 8'h0A);
        chk("single_ack0", ack0, 1'b1);
        step();
        req0 = 0;

        // Ties alternate, requester 0 first after reset.
        do_reset();
        exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h11; exp_seq[3] = 8'h22;
        req0 = 1; req1 = 1; din0 = 8'h11; din1 = 8'h22;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("rr_q_din", q_din, exp_seq[i]);
            chk("rr_ack0", ack0, (i % 2) == 0);
            step();
        end
        idle_inputs();

        // Full blocks writes and stall_cnt saturates.
        do_reset();
        req1 = 1; din1 = 8'h5A; q_full = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("full_q_wr", q_wr, 1'b0);
            chk("full_ack1", ack1, 1'b0);
            step();
        end
        chk("stall_3", stall_cnt, 8'd3);
        repeat (300) step();
        chk("stall_sat", stall_cnt, 8'hFF);
        idle_inputs();

        // Reads paced one per two cycles.
        do_reset();
        q_empty = 0; rd_req = 1; q_dout = 8'h09;
        for (int i = 0; i < 6; i++) begin
            #2;
            chk("rd_q_rd", q_rd, (i % 2) == 0);
            chk("rd_valid", rd_valid, (i % 2) == 1);
            chk("rd_data", rd_data, (i % 2) == 1 ? 8'h09 : 8'h00);
            step();
        end

        // Empty cq suppresses reads entirely.
        q_empty = 1;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("empty_q_rd", q_rd, 1'b0);
            chk("empty_valid", rd_valid, 1'b0);
            step();
        end

        // Reset while a pop is in flight drops it, then tie goes to requester 0.
        q_empty = 0; q_dout = 8'h77;
        #2;
        chk("inflight_q_rd", q_rd, 1'b1);
        step();
        reset = 1; rd_req = 0;
        #2;
        chk("rst_drop_valid", rd_valid, 1'b0);
        chk("rst_drop_data", rd_data, 8'h00);
        step();
        reset = 0;
        req0 = 1; req1 = 1; din0 = 8'hA0; din1 = 8'hB1;
        #2;
        chk("post_rst_valid", rd_valid, 1'b0);
        chk("post_rst_ack0", ack0, 1'b1);
        chk("post_rst_ack1", ack1, 1'b0);
        step();
        idle_inputs();

        // Random traffic honouring the hold-until-ack producer protocol.
        for (int n = 0; n < 3000; n++) begin
            bit a0, a1;
            reset   = ($urandom_range(0, 99) == 0);
            q_full  = ($urandom_range(0, 3) == 0);
            q_empty = ($urandom_range(0, 3) == 0);
            rd_req  = $urandom_range(0, 1);
            q_dout  = 8'($urandom);
            #6;
            a0 = ack0;
            a1 = ack1;
            step();
            if (!req0 || a0) begin
                req0 = $urandom_range(0, 1);
                din0 = 8'($urandom);
            end
            if (!req1 || a1) begin
                req1 = $urandom_range(0, 1);
                din1 = 8'($urandom);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cq_sched.md
CQ_SCHED -- requirements
Module: cq_sched

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports req0/req1, input, 1 bit each: producer write request, held until acked.
REQ-004 SHALL have ports din0/din1, input, 8 bits each: producer data, stable while its req is high.
REQ-005 SHALL have ports ack0/ack1, output, 1 bit each: one-cycle pulse, word accepted this edge.
REQ-006 SHALL have ports q_wr (output, 1), q_din (output, 8), q_full (input, 1): cq write side; cq captures q_din at the edge where q_wr=1 and q_full=0.
REQ-007 SHALL have ports q_rd (output, 1), q_empty (input, 1), q_dout (input, 8): cq read side; q_dout is valid in the cycle after q_rd.
REQ-008 SHALL have ports rd_req (input, 1), rd_valid (output, 1), rd_data (output, 8): consumer side.
REQ-009 SHALL have port stall_cnt, output, 8 bits: saturating count of cycles with a request blocked by q_full.

Function
REQ-010 Write grant SHALL be combinational: q_wr = (req0|req1) & ~q_full & ~reset.
REQ-011 Only one req high -> that requester SHALL be granted.
REQ-012 Both req high -> grant SHALL go to the requester not granted last (round-robin); register last_gnt updates only on an actual write.
REQ-013 ackN SHALL equal q_wr & (grant==N); q_din SHALL equal din of the granted requester, 0 when q_wr=0.
REQ-014 q_full=1 SHALL block all writes: no ack, last_gnt unchanged.
REQ-015 stall_cnt SHALL increment by 1 each cycle with (req0|req1)&q_full, saturating at 8'hFF, never wrapping.
REQ-016 Read FSM SHALL have states R_IDLE and R_DATA.
REQ-017 In R_IDLE: q_rd = rd_req & ~q_empty; if q_rd=1, next state R_DATA, else stay.
REQ-018 In R_DATA: q_rd=0, rd_valid=1, rd_data=q_dout; next state R_IDLE unconditionally (at most one read every 2 cycles).
REQ-019 rd_data SHALL be 0 whenever rd_valid=0.
REQ-020 rd_req with q_empty=1 SHALL produce no q_rd and no rd_valid; the request is not remembered.
REQ-021 Write and read paths SHALL be independent; a write and a q_rd in the same cycle are legal.
REQ-022 q_full while a read is in flight SHALL still block writes that cycle (no look-ahead on freed space).

Reset
REQ-023 While reset=1: ack0=ack1=0, q_wr=0, q_din=0, q_rd=0, rd_valid=0, rd_data=0.
REQ-024 At the first edge with reset=1: read FSM -> R_IDLE, last_gnt -> 1 (requester 0 wins first tie), stall_cnt -> 0.
REQ-025 Reset during R_DATA SHALL abandon the pending read; the word popped from cq is discarded.

Structure
REQ-026 A shared package SHALL hold the data width (8), the read-FSM state encoding, and the stall_cnt saturation value.
REQ-027 The round-robin grant (last_gnt register plus select) SHALL be a sub-module named cq_rr_arb2; cq itself is not instantiated inside cq_sched.

Verification
REQ-028 req0=1, din0=8'h0A, q_full=0, req1=0 -> same cycle q_wr=1, q_din=8'h0A, ack0=1.
REQ-029 req0=req1=1, din0=8'h11, din1=8'h22 held 4 cycles, q_full=0 -> q_din sequence 11,22,11,22; acks alternate starting with ack0.
REQ-030 q_full=1 for 3 cycles with req1=1 -> no q_wr, no ack1, stall_cnt 0->3; 300 blocked cycles -> stall_cnt holds 8'hFF.
REQ-031 q_empty=0, rd_req held high, q_dout=8'h09 -> q_rd at cycles 0,2,4; rd_valid with rd_data=8'h09 at cycles 1,3,5.
REQ-032 rd_req=1, q_empty=1 -> q_rd=0, rd_valid=0 every cycle.
REQ-033 reset=1 in the cycle after q_rd -> rd_valid=0, FSM in R_IDLE; then req0/req1 both high -> ack0 first.
